// File: rtl/riscv_mem_pkg.sv
// Shared widths and FSM encoding for the cache-line to memory-word bridge.
package riscv_mem_pkg;
    localparam int LINE_BITS  = 512;
    localparam int WORD_BITS  = 32;
    localparam int BEATS      = LINE_BITS / WORD_BITS;
    localparam int LINE_OFF_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/mem_line_bridge.sv
// Splits a cache-line read/write into BEATS word transfers on a req/ack bus,
// reassembling read words into one line and strobing line_ready on completion.
module mem_line_bridge #(
    parameter int LINE_BITS = riscv_mem_pkg::LINE_BITS,
    parameter int WORD_BITS = riscv_mem_pkg::WORD_BITS,
    parameter int BEATS     = LINE_BITS / WORD_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line_addr_valid,
    input  logic [31:0]          line_addr,
    input  logic                 line_write_valid,
    input  logic [LINE_BITS-1:0] line_write_data,
    output logic                 line_ready,
    output logic [LINE_BITS-1:0] line_read_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_BITS-1:0] mem_rdata
);
    import riscv_mem_pkg::*;

    localparam int BEAT_W     = $clog2(BEATS);
    localparam int WORD_OFF_W = $clog2(WORD_BITS / 8);
    localparam int TAG_W      = 32 - LINE_OFF_W;

    state_t                 state;
    logic [TAG_W-1:0]       tag_q;
    logic [BEAT_W-1:0]      beat;
    logic [BEAT_W-1:0]      beat_nxt;
    logic [LINE_BITS-1:0]   line_buf;
    logic [LINE_BITS-1:0]   line_filled;
    logic                   beat_ack;
    logic                   last_beat;
    logic                   unused_offset;

    // Byte offset within the line is never used for addressing.
    assign unused_offset = ^line_addr[LINE_OFF_W-1:0];

    assign beat_ack  = mem_req && mem_ack;
    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    assign beat_nxt  = beat + 1'b1;

    // Line buffer with the word arriving this cycle merged in.
    always_comb begin
        line_filled = line_buf;
        line_filled[beat*WORD_BITS +: WORD_BITS] = mem_rdata;
    end

    function automatic logic [31:0] word_addr(input logic [TAG_W-1:0] tag,
                                              input logic [BEAT_W-1:0] b);
        return 32'({tag, b, {WORD_OFF_W{1'b0}}});
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            beat           <= '0;
            line_ready     <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            line_read_data <= '0;
        end else begin
            line_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (line_addr_valid) begin
                        tag_q     <= line_addr[31:LINE_OFF_W];
                        line_buf  <= line_write_data;
                        beat      <= '0;
                        state     <= line_write_valid ? WRITE : READ;
                        mem_req   <= 1'b1;
                        mem_we    <= line_write_valid;
                        mem_addr  <= word_addr(line_addr[31:LINE_OFF_W], '0);
                        mem_wdata <= line_write_data[WORD_BITS-1:0];
                    end
                end
                READ, WRITE: begin
                    if (beat_ack) begin
                        if (state == READ)
                            line_buf <= line_filled;
                        beat <= beat_nxt;
                        if (last_beat) begin
                            // Drop the request on the final ack so no extra bus cycle appears.
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            mem_we     <= 1'b0;
                            line_ready <= 1'b1;
                            if (state == READ)
                                line_read_data <= line_filled;
                        end else begin
                            mem_addr  <= word_addr(tag_q, beat_nxt);
                            mem_wdata <= line_buf[beat_nxt*WORD_BITS +: WORD_BITS];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
